// File: rtl/wb_reg_file_if.sv
// wb_reg_file_if
// Bundles the MEM/WB write-back inputs, the two ID-stage read ports and the
// debug/trace outputs of the write-back register file into one interface.
//
// Signals:
//   RegDmOut, RegAluOut  write-back candidates (load data / ALU result)
//   RegRd, RegRegW       destination register and write enable
//   RegMem2R             write-back select (1 = load data, 0 = ALU result)
//   Rs, Rt               read addresses from the ID stage
//   RsData, RtData       combinational read data with write-through bypass
//   WbData               selected write-back value (combinational)
//   WbCount              number of committed writes (registered)
//   LastRd, LastData     destination/data of the most recent commit
//
// Modports:
//   master  drives the pipeline inputs and observes the results
//   slave   the register file itself
interface wb_reg_file_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] RegDmOut;
    logic [WIDTH-1:0] RegAluOut;
    logic [4:0]       RegRd;
    logic             RegRegW;
    logic             RegMem2R;
    logic [4:0]       Rs;
    logic [4:0]       Rt;
    logic [WIDTH-1:0] RsData;
    logic [WIDTH-1:0] RtData;
    logic [WIDTH-1:0] WbData;
    logic [31:0]      WbCount;
    logic [4:0]       LastRd;
    logic [WIDTH-1:0] LastData;

    modport master (
        output RegDmOut, RegAluOut, RegRd, RegRegW, RegMem2R, Rs, Rt,
        input  RsData, RtData, WbData, WbCount, LastRd, LastData
    );

    modport slave (
        input  RegDmOut, RegAluOut, RegRd, RegRegW, RegMem2R, Rs, Rt,
        output RsData, RtData, WbData, WbCount, LastRd, LastData
    );
endinterface

// File: rtl/wb_reg_file.sv
// wb_reg_file
// Write-back stage and 32x32 general-purpose register file of the 5-stage
// MIPS pipeline. Selects the write-back value from the MEM/WB outputs,
// commits it to the register array and serves two combinational read ports
// with same-cycle write-through bypass. Register 0 is hardwired to zero.
// A commit counter and last-write trace registers support debug.
//
// Ports:
//   clk   single clock, all state updates on the rising edge
//   rst   synchronous active-high reset; clears registers, counter, trace
//   bus   wb_reg_file_if.slave carrying the MEM/WB inputs, read ports
//         and debug outputs
module wb_reg_file #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    wb_reg_file_if.slave  bus
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] wbData;
    logic             commit;
    logic [31:0]      wbCountQ;
    logic [4:0]       lastRdQ;
    logic [WIDTH-1:0] lastDataQ;
    logic [WIDTH-1:0] rsData;
    logic [WIDTH-1:0] rtData;

    // Reset suppresses commit so a write presented in the reset cycle is lost
    // and the bypass never forwards it.
    always_comb begin
        wbData = bus.RegMem2R ? bus.RegDmOut : bus.RegAluOut;
        commit = bus.RegRegW && (bus.RegRd != 5'd0) && !rst;
    end

    // Read ports: reset and r0 force zero, then the in-flight commit is
    // forwarded ahead of the array contents.
    always_comb begin
        rsData = '0;
        if (!rst && bus.Rs != 5'd0) begin
            if (commit && bus.RegRd == bus.Rs) begin
                rsData = wbData;
            end else begin
                rsData = regs[bus.Rs];
            end
        end
    end

    always_comb begin
        rtData = '0;
        if (!rst && bus.Rt != 5'd0) begin
            if (commit && bus.RegRd == bus.Rt) begin
                rtData = wbData;
            end else begin
                rtData = regs[bus.Rt];
            end
        end
    end

    // Register array. Entry 0 is only ever written by reset, so it stays zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[bus.RegRd] <= wbData;
        end
    end

    // Commit counter and last-write trace; the counter wraps modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbCountQ  <= '0;
            lastRdQ   <= '0;
            lastDataQ <= '0;
        end else if (commit) begin
            wbCountQ  <= wbCountQ + 32'd1;
            lastRdQ   <= bus.RegRd;
            lastDataQ <= wbData;
        end
    end

    assign bus.WbData   = wbData;
    assign bus.RsData   = rsData;
    assign bus.RtData   = rtData;
    assign bus.WbCount  = wbCountQ;
    assign bus.LastRd   = lastRdQ;
    assign bus.LastData = lastDataQ;

endmodule
